// File: rtl/pixel_sensor_pkg.sv
// Shared widths and the saturating integrator add for the pixel_sensor block.
package pixel_sensor_pkg;

    localparam int unsigned PIXEL_BITS = 8;
    localparam int unsigned V_BITS     = PIXEL_BITS + 8;

    // Accumulate one exposure step, clamping at full scale instead of wrapping.
    function automatic logic [V_BITS-1:0] sat_add(input logic [V_BITS-1:0]     a,
                                                  input logic [PIXEL_BITS-1:0] b);
        logic [V_BITS:0] s;
        s = {1'b0, a} + (V_BITS+1)'(b);
        return s[V_BITS] ? {V_BITS{1'b1}} : s[V_BITS-1:0];
    endfunction

endpackage

// File: rtl/pixel_sensor_if.sv
// Control, ramp/counter and column-data signals between the sensor sequencer and one pixel.
interface pixel_sensor_if;
    import pixel_sensor_pkg::*;

    logic [PIXEL_BITS-1:0] LIGHT;
    logic                  RAMP;
    logic                  ERASE;
    logic                  EXPOSE;
    logic                  READ;
    logic [PIXEL_BITS-1:0] COUNTER;
    logic [PIXEL_BITS-1:0] DATA;

    modport master (output LIGHT, RAMP, ERASE, EXPOSE, READ, COUNTER, input DATA);
    modport slave  (input LIGHT, RAMP, ERASE, EXPOSE, READ, COUNTER, output DATA);

endinterface

// File: rtl/pixel_sensor_comparator.sv
// Single-slope ADC back end: ramp level tracking, first-crossing detect and code latch.
module pixel_comparator
    import pixel_sensor_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic [PIXEL_BITS-1:0] i_vpix,
    input  logic                  i_ramp,
    input  logic [PIXEL_BITS-1:0] i_counter,
    output logic [PIXEL_BITS-1:0] o_code
);

    logic [PIXEL_BITS-1:0] r_ramp_lvl;
    logic                  r_ramp_d;
    logic                  r_tripped;
    logic [PIXEL_BITS-1:0] r_code_q;

    logic                  w_ramp_edge;
    logic [PIXEL_BITS-1:0] w_lvl_next;

    assign w_ramp_edge = i_ramp & ~r_ramp_d;
    assign w_lvl_next  = (r_ramp_lvl == {PIXEL_BITS{1'b1}}) ? r_ramp_lvl
                                                            : r_ramp_lvl + PIXEL_BITS'(1);

    // Trip compares against the post-increment level so the crossing edge itself latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ramp_lvl <= '0;
            r_ramp_d   <= 1'b0;
            r_tripped  <= 1'b0;
            r_code_q   <= '0;
        end else begin
            r_ramp_d <= i_ramp;
            if (i_clear) begin
                r_ramp_lvl <= '0;
                r_tripped  <= 1'b0;
            end else if (w_ramp_edge) begin
                r_ramp_lvl <= w_lvl_next;
                if (!r_tripped && (w_lvl_next >= i_vpix)) begin
                    r_code_q  <= i_counter;
                    r_tripped <= 1'b1;
                end
            end
        end
    end

    assign o_code = r_code_q;

endmodule

// File: rtl/pixel_sensor.sv
// One image-sensor pixel: light integrator, in-pixel ADC memory and column driver.
// Define PIXEL_SENSOR_TRISTATE_EN to float DATA while READ is low (shared column bus).
module pixel_sensor
    import pixel_sensor_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    pixel_sensor_if.slave bus
);

    logic [V_BITS-1:0]     r_v;
    logic [PIXEL_BITS-1:0] w_vpix;
    logic [PIXEL_BITS-1:0] w_code;

    // Integrator: erase wins over exposure, exposure saturates at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= '0;
        end else if (bus.ERASE) begin
            r_v <= '0;
        end else if (bus.EXPOSE) begin
            r_v <= sat_add(r_v, bus.LIGHT);
        end
    end

    assign w_vpix = r_v[V_BITS-1 -: PIXEL_BITS];

    pixel_comparator u_cmp (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (bus.ERASE | bus.EXPOSE),
        .i_vpix    (w_vpix),
        .i_ramp    (bus.RAMP),
        .i_counter (bus.COUNTER),
        .o_code    (w_code)
    );

`ifdef PIXEL_SENSOR_TRISTATE_EN
    assign bus.DATA = bus.READ ? w_code : {PIXEL_BITS{1'bz}};
`else
    assign bus.DATA = bus.READ ? w_code : '0;
`endif

endmodule

// File: tb/tb_pixel_sensor.sv
// Directed self-checking bench for pixel_sensor: exposure, ramp conversion, saturation, reset abort, readout.
module tb_pixel_sensor;
    import pixel_sensor_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    pixel_sensor_if bus ();

    pixel_sensor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIXEL_SENSOR_TRISTATE_EN
    localparam logic [PIXEL_BITS-1:0] IDLE_DATA = {PIXEL_BITS{1'bz}};
`else
    localparam logic [PIXEL_BITS-1:0] IDLE_DATA = '0;
`endif

    task automatic check(input string tag, input logic [PIXEL_BITS-1:0] obs,
                         input logic [PIXEL_BITS-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic erase();
        bus.ERASE = 1'b1;
        tick();
        bus.ERASE = 1'b0;
    endtask

    task automatic expose(input logic [PIXEL_BITS-1:0] light, input int cycles);
        bus.LIGHT  = light;
        bus.EXPOSE = 1'b1;
        repeat (cycles) tick();
        bus.EXPOSE = 1'b0;
    endtask

    task automatic ramp_edge(input logic [PIXEL_BITS-1:0] cnt);
        bus.COUNTER = cnt;
        bus.RAMP    = 1'b1;
        tick();
        bus.RAMP    = 1'b0;
        tick();
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        bus.LIGHT   = '0;
        bus.RAMP    = 1'b0;
        bus.ERASE   = 1'b0;
        bus.EXPOSE  = 1'b0;
        bus.READ    = 1'b1;
        bus.COUNTER = '0;
        tick();
        tick();
        check("reset_data", bus.DATA, 8'd0);
        reset = 1'b0;

        // Dark pixel trips on the first edge; later edges must not overwrite.
        erase();
        ramp_edge(8'd9);
        check("dark_trip", bus.DATA, 8'd9);
        for (int k = 0; k < 3; k++) ramp_edge(8'd77);
        check("dark_hold", bus.DATA, 8'd9);

        // 64 x 4 = 256 -> vpix 1, trip at edge 1.
        erase();
        expose(8'd4, 64);
        for (int k = 1; k <= 3; k++) ramp_edge(8'(k));
        check("vpix1", bus.DATA, 8'd1);

        // 255 x 255 = 65025 -> vpix 254.
        erase();
        expose(8'd255, 255);
        for (int k = 1; k <= 253; k++) ramp_edge(8'(k));
        check("vpix254_before", bus.DATA, 8'd1);
        ramp_edge(8'd254);
        check("vpix254_trip", bus.DATA, 8'd254);
        ramp_edge(8'd255);
        ramp_edge(8'd0);
        check("vpix254_hold", bus.DATA, 8'd254);

        // 300 x 255 saturates at 65535 -> vpix 255, trip at edge 255.
        erase();
        expose(8'd255, 300);
        for (int k = 1; k <= 254; k++) ramp_edge(8'(k));
        check("sat_before", bus.DATA, 8'd254);
        ramp_edge(8'd255);
        check("sat_trip", bus.DATA, 8'd255);
        for (int k = 0; k < 5; k++) ramp_edge(8'(k));
        check("sat_hold", bus.DATA, 8'd255);

        // ERASE dominates EXPOSE: v stays 0, so the first edge trips.
        bus.ERASE = 1'b1;
        expose(8'd255, 10);
        bus.ERASE = 1'b0;
        ramp_edge(8'd42);
        check("erase_wins", bus.DATA, 8'd42);

        // Held-high RAMP counts once: vpix 2 needs two separate edges.
        erase();
        expose(8'd255, 3);
        bus.COUNTER = 8'd50;
        bus.RAMP    = 1'b1;
        repeat (5) tick();
        bus.RAMP    = 1'b0;
        tick();
        check("held_ramp_once", bus.DATA, 8'd42);
        ramp_edge(8'd60);
        check("second_edge", bus.DATA, 8'd60);

        // Reset mid-ramp clears code and tripped.
        erase();
        expose(8'd255, 100);
        for (int k = 1; k <= 10; k++) ramp_edge(8'(k));
        reset = 1'b1;
        tick();
        check("reset_code", bus.DATA, 8'd0);
        reset = 1'b0;
        ramp_edge(8'd33);
        check("reset_untrip", bus.DATA, 8'd33);

        // Readout is combinational from READ.
        bus.READ = 1'b0;
        #1;
        check("read_low", bus.DATA, IDLE_DATA);
        bus.READ = 1'b1;
        #1;
        check("read_high", bus.DATA, 8'd33);
        bus.READ = 1'b0;
        #1;
        check("read_low2", bus.DATA, IDLE_DATA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
